rf_scoreboard: RTL
==================

// Module: rf_scoreboard
// PURPOSE
// Register-file hazard scheduler for the 5-stage pipeline. Keeps a per-GPR count
// of in-flight writes issued from decode but not yet retired at writeback.
// Stalls decode while a source GPR has a pending write, or while the destination
// counter would overflow. Sits between ds (issue side) and ws (release side via
// ws_to_rf_bus fields).
// PARAMETERS
// NREG        32  number of GPRs tracked; r0 is never tracked
// CNT_W       2   width of each per-register pending counter
// MAX_PEND    3   max in-flight writes per GPR; must be <= 2**CNT_W-1
// WB_BYPASS   1   1: a same-cycle ws release of rX unblocks a ds read of rX
//                 (RF is write-through); 0: unblock one cycle later
// PORTS
// clk          in   1   clock
// reset        in   1   synchronous, active-high
// ds_valid     in   1   decode holds a valid instruction
// ds_rj_en     in   1   instruction reads rj
// ds_rj        in   5   rj index
// ds_rk_en     in   1   instruction reads rk/rd as a source
// ds_rk        in   5   rk index
// ds_gr_we     in   1   instruction writes a GPR
// ds_dest      in   5   destination index
// ds_fire      in   1   decode->execute transfer this cycle (ds_valid & es_allowin & !ds_stall)
// ws_rf_we     in   1   writeback commits a GPR write this cycle
// ws_waddr     in   5   writeback destination index
// flush        in   1   kill all in-flight instructions younger than ws
// ds_stall     out  1   decode must hold (combinational)
// busy         out  NREG  bit i = counter[i] != 0 (registered state)
// err          out  1   sticky: overflow/underflow detected
// BEHAVIOUR
// - Reset: all counters 0, busy=0, err=0, ds_stall=0.
// - Issue: ds_fire & ds_gr_we & ds_dest!=0 -> cnt[ds_dest] += 1 next cycle.
// - Release: ws_rf_we & ws_waddr!=0 -> cnt[ws_waddr] -= 1 next cycle.
// - Same register issued and released in one cycle -> counter unchanged.
// - Index 0: never incremented, decremented, or stalled on; busy[0]=0 always.
// - src_hit(x) = cnt[x]!=0 and not (WB_BYPASS & ws_rf_we & ws_waddr==x & cnt[x]==1).
// - ds_stall = ds_valid & ((ds_rj_en & ds_rj!=0 & src_hit(ds_rj)) |
//   (ds_rk_en & ds_rk!=0 & src_hit(ds_rk)) |
//   (ds_gr_we & ds_dest!=0 & cnt[ds_dest]==MAX_PEND)).
// - ds_stall=0 whenever ds_valid=0; does not depend on ds_fire (no comb loop).
// - ds_fire while ds_stall=1 is a protocol error: counter is not incremented,
//   err is set.
// - Release on a counter already at 0: counter stays 0, err is set.
// - Increment at MAX_PEND is blocked (see stall); never wraps.
// - flush: all counters 0 next cycle; same-cycle issue and release are ignored;
//   err is unaffected. Owner guarantees ws holds no live write when flush asserts.
// - reset mid-operation overrides flush/issue/release; err cleared only by reset.
// - Latency: counter update visible to busy/ds_stall 1 cycle after the event;
//   release bypass (WB_BYPASS=1) is same-cycle.
// TESTING
// - Issue r5 (fire, dest=5); next cycle read rj=5 -> ds_stall=1, busy[5]=1 until ws
//   releases r5; with WB_BYPASS=1 stall drops in the release cycle, with 0 one
//   cycle later.
// - Issue three writes to r7 back-to-back, then fourth instr gr_we dest=7 ->
//   ds_stall=1 (cnt=3); one release -> cnt=2, stall drops next cycle.
// - Same-cycle fire dest=9 and ws release r9 with cnt[9]=1 -> cnt[9] stays 1,
//   busy[9]=1.
// - Reads/writes of r0 (rj=0, dest=0, ws_waddr=0) -> no stall, busy=0, err=0.
// - Fill r3,r4 pending; assert flush together with fire dest=6 -> next cycle busy=0,
//   ds_stall=0, err=0.
// - Release r12 with cnt=0, and fire while ds_stall=1 -> err=1 sticky; counters
//   unchanged; reset clears err.

Source files
------------

// File: rtl/rf_scoreboard_if.sv
// Decode-issue / writeback-release bundle for the register-file hazard scoreboard.
// The master side drives decode and writeback requests; the slave side is the scoreboard.
interface rf_scoreboard_if #(
    parameter int NREG = 32
);
    logic            ds_valid;
    logic            ds_rj_en;
    logic [4:0]      ds_rj;
    logic            ds_rk_en;
    logic [4:0]      ds_rk;
    logic            ds_gr_we;
    logic [4:0]      ds_dest;
    logic            ds_fire;
    logic            ws_rf_we;
    logic [4:0]      ws_waddr;
    logic            flush;
    logic            ds_stall;
    logic [NREG-1:0] busy;
    logic            err;

    modport master (
        output ds_valid, ds_rj_en, ds_rj, ds_rk_en, ds_rk, ds_gr_we, ds_dest,
               ds_fire, ws_rf_we, ws_waddr, flush,
        input  ds_stall, busy, err
    );

    modport slave (
        input  ds_valid, ds_rj_en, ds_rj, ds_rk_en, ds_rk, ds_gr_we, ds_dest,
               ds_fire, ws_rf_we, ws_waddr, flush,
        output ds_stall, busy, err
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-GPR pending-write counters: decode stalls on RAW hazards against in-flight
// writes and on destination counter saturation; writeback releases entries.
module rf_scoreboard #(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter int MAX_PEND  = 3,
    parameter int WB_BYPASS = 1
) (
    input  logic          clk,
    input  logic          reset,
    rf_scoreboard_if.slave sb
);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t MAX_CNT = cnt_t'(MAX_PEND);
    localparam cnt_t ONE_CNT = cnt_t'(1);

    cnt_t cnt      [NREG];
    cnt_t cnt_next [NREG];
    logic err_q;

    logic rj_hit;
    logic rk_hit;
    logic dest_full;
    logic stall;
    logic issue;
    logic release_req;
    logic set_err;

    // A writeback retiring the last pending write this cycle is forwarded
    // through the write-through RF, so the reader need not wait for the count.
    always_comb begin
        rj_hit = sb.ds_rj_en && (sb.ds_rj != 5'd0) && (cnt[sb.ds_rj] != '0) &&
                 !((WB_BYPASS != 0) && sb.ws_rf_we && (sb.ws_waddr == sb.ds_rj) &&
                   (cnt[sb.ds_rj] == ONE_CNT));
        rk_hit = sb.ds_rk_en && (sb.ds_rk != 5'd0) && (cnt[sb.ds_rk] != '0) &&
                 !((WB_BYPASS != 0) && sb.ws_rf_we && (sb.ws_waddr == sb.ds_rk) &&
                   (cnt[sb.ds_rk] == ONE_CNT));
        dest_full = sb.ds_gr_we && (sb.ds_dest != 5'd0) && (cnt[sb.ds_dest] == MAX_CNT);
        stall     = sb.ds_valid && (rj_hit || rk_hit || dest_full);

        issue       = sb.ds_fire && sb.ds_gr_we && (sb.ds_dest != 5'd0) && !stall &&
                      (cnt[sb.ds_dest] != MAX_CNT);
        release_req = sb.ws_rf_we && (sb.ws_waddr != 5'd0);
        set_err     = (sb.ds_fire && stall) || (release_req && (cnt[sb.ws_waddr] == '0));
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_next[i] = cnt[i];
            if (sb.flush) begin
                cnt_next[i] = '0;
            end else begin
                if (issue && (sb.ds_dest == 5'(i)) && !(release_req && (sb.ws_waddr == 5'(i)))) begin
                    cnt_next[i] = cnt[i] + ONE_CNT;
                end else if (release_req && (sb.ws_waddr == 5'(i)) &&
                             !(issue && (sb.ds_dest == 5'(i))) && (cnt[i] != '0)) begin
                    cnt_next[i] = cnt[i] - ONE_CNT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            sb.busy[i] = (cnt[i] != '0);
        end
    end

    assign sb.ds_stall = stall;
    assign sb.err      = err_q;
endmodule
